// File: rtl/lti_pkg.sv
// Shared definitions for the LTI sample driver: FSM encoding, sticky-flag
// bit positions and the sticky-flag update rule.
package lti_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam int FLAG_UNDERRUN = 0;
   localparam int FLAG_OVERRUN  = 1;
   localparam int FLAG_TIMEOUT  = 2;
   localparam int NUM_FLAGS     = 3;

   // Clear drops every flag, but a flag being set in the same cycle survives.
   function automatic logic [NUM_FLAGS-1:0] update_flags(
      input logic [NUM_FLAGS-1:0] cur,
      input logic                 clr,
      input logic [NUM_FLAGS-1:0] set
   );
      return (clr ? '0 : cur) | set;
   endfunction

endpackage

// File: rtl/lti_tick_gen.sv
// Sample-period counter: counts 0..DIV-1 while enabled and pulses tick for
// the single cycle spent at DIV-1. Disabling holds the count at zero.
module lti_tick_gen
   import lti_pkg::*;
#(
   parameter int DIV = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: freeze at zero when disabled, wrap after the last count.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/lti_sample_driver.sv
// Drives one upstream sample per period into an LTI system, waits a bounded
// time for its output strobe, and hands the captured result downstream with
// sticky underrun/overrun/timeout reporting.
module lti_sample_driver
   import lti_pkg::*;
#(
   parameter int IW  = 16,
   parameter int OW  = 20,
   parameter int DIV = 100,
   parameter int TO  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   input  logic [IW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [IW-1:0] sys_in,
   output logic          sys_ce_in,
   input  logic [OW-1:0] sys_out,
   input  logic          sys_ce_out,
   output logic [OW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          underrun,
   output logic          overrun,
   output logic          timeout,
   output logic [15:0]   sample_count
);

   // Wait counter only ever reaches TO-1 before leaving WAIT.
   localparam int             WCW     = (TO > 0) ? $clog2(TO + 1) : 1;
   localparam logic [WCW-1:0] TO_LAST = WCW'(TO - 1);

   state_e                 state_q, state_d;
   logic                   tick;
   logic                   is_issue, is_wait, take, capture, expire;
   logic [WCW-1:0]         wcnt_q, wcnt_d;
   logic [IW-1:0]          sys_in_q, sys_in_d;
   logic                   sys_ce_in_q, sys_ce_in_d;
   logic [OW-1:0]          out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic [NUM_FLAGS-1:0]   flags_q, flags_d, flag_set;
   logic [15:0]            sample_count_q, sample_count_d;

   lti_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: ISSUE lasts one cycle; WAIT ends on capture or expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tick) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (capture || expire) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM decoded outputs; ce_out is only honoured while waiting.
   always_comb begin
      is_issue = (state_q == ST_ISSUE);
      is_wait  = (state_q == ST_WAIT);
      take     = is_issue && in_valid;
      in_ready = take;
      capture  = is_wait && sys_ce_out;
      expire   = is_wait && !sys_ce_out && (wcnt_q == TO_LAST);
   end

   // Datapath next state: sample latch, strobe, result capture, flags, count.
   always_comb begin
      wcnt_d      = is_wait ? (wcnt_q + WCW'(1)) : '0;
      sys_in_d    = take ? in_data : sys_in_q;
      sys_ce_in_d = is_issue;
      out_data_d  = capture ? sys_out : out_data_q;

      out_valid_d = out_valid_q;
      if (capture) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      flag_set                = '0;
      flag_set[FLAG_UNDERRUN] = is_issue && !in_valid;
      flag_set[FLAG_OVERRUN]  = capture && out_valid_q && !out_ready;
      flag_set[FLAG_TIMEOUT]  = expire;
      flags_d                 = update_flags(flags_q, clr, flag_set);

      sample_count_d = capture ? (sample_count_q + 16'd1) : sample_count_q;
   end

   // Datapath registers; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wcnt_q         <= '0;
         sys_in_q       <= '0;
         sys_ce_in_q    <= 1'b0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         flags_q        <= '0;
         sample_count_q <= '0;
      end else begin
         wcnt_q         <= wcnt_d;
         sys_in_q       <= sys_in_d;
         sys_ce_in_q    <= sys_ce_in_d;
         out_data_q     <= out_data_d;
         out_valid_q    <= out_valid_d;
         flags_q        <= flags_d;
         sample_count_q <= sample_count_d;
      end
   end

   assign sys_in       = sys_in_q;
   assign sys_ce_in    = sys_ce_in_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign underrun     = flags_q[FLAG_UNDERRUN];
   assign overrun      = flags_q[FLAG_OVERRUN];
   assign timeout      = flags_q[FLAG_TIMEOUT];
   assign sample_count = sample_count_q;

endmodule

// File: tb/tb_lti_sample_driver.sv
// Directed bench for lti_sample_driver with a delayed-strobe LTI responder
// and a queue of expected captured results.
module tb_lti_sample_driver;

   localparam int IW  = 16;
   localparam int OW  = 20;
   localparam int DIV = 16;
   localparam int TO  = 8;

   logic          clk = 1'b0;
   logic          rst_n, en, clr;
   logic [IW-1:0] in_data;
   logic          in_valid, in_ready;
   logic [IW-1:0] sys_in;
   logic          sys_ce_in;
   logic [OW-1:0] sys_out;
   logic          sys_ce_out;
   logic [OW-1:0] out_data;
   logic          out_valid, out_ready;
   logic          underrun, overrun, timeout;
   logic [15:0]   sample_count;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            rdy_cnt = 0;
   int            resp_delay = 3;
   logic [OW-1:0] exp_q[$];

   always #5 clk = ~clk;

   lti_sample_driver #(
      .IW (IW), .OW (OW), .DIV (DIV), .TO (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .clr          (clr),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sys_in       (sys_in),
      .sys_ce_in    (sys_ce_in),
      .sys_out      (sys_out),
      .sys_ce_out   (sys_ce_out),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .underrun     (underrun),
      .overrun      (overrun),
      .timeout      (timeout),
      .sample_count (sample_count)
   );

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (in_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;

   // Stand-in LTI response to a given input sample.
   function automatic logic [OW-1:0] resp_of(input logic [IW-1:0] x);
      return {4'hA, x ^ 16'h5A5A};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sys_in"},       32'(sys_in),       32'h0);
      check({tag, "_sys_ce_in"},    32'(sys_ce_in),    32'h0);
      check({tag, "_in_ready"},     32'(in_ready),     32'h0);
      check({tag, "_out_data"},     32'(out_data),     32'h0);
      check({tag, "_out_valid"},    32'(out_valid),    32'h0);
      check({tag, "_flags"},        32'({underrun, overrun, timeout}), 32'h0);
      check({tag, "_sample_count"}, 32'(sample_count), 32'h0);
   endtask

   task automatic wait_ce(output int t);
      bit found;
      found = 1'b0;
      t = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (sys_ce_in === 1'b1) begin
            found = 1'b1;
            t = cyc;
         end
      end
      check("ce_in_seen", 32'(found), 32'h1);
   endtask

   task automatic wait_ov();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) found = 1'b1;
      end
      check("out_valid_seen", 32'(found), 32'h1);
   endtask

   // Responder: answers each sys_ce_in with sys_ce_out resp_delay cycles later.
   initial begin : responder
      int            d;
      logic [OW-1:0] v;
      sys_ce_out = 1'b0;
      sys_out    = '0;
      forever begin
         @(negedge clk);
         if (sys_ce_in === 1'b1 && resp_delay > 0) begin
            d = resp_delay;
            v = resp_of(sys_in);
            repeat (d) @(negedge clk);
            sys_out    = v;
            sys_ce_out = 1'b1;
            @(negedge clk);
            sys_ce_out = 1'b0;
         end
      end
   end

   initial begin : main
      int            t, tprev, n;
      logic [OW-1:0] e, last_cap;
      logic [IW-1:0] last_in;
      logic [IW-1:0] pat [3];
      pat = '{16'h0123, 16'h7FFF, 16'h0123};
      tprev = 0;

      rst_n = 1'b0; en = 1'b0; clr = 1'b0;
      in_valid = 1'b1; in_data = 16'h0123; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      en    = 1'b1;

      // Normal periods.
      for (int i = 0; i < 3; i++) begin
         in_data = pat[i];
         last_in = pat[i];
         exp_q.push_back(resp_of(pat[i]));
         wait_ce(t);
         check("sys_in_period", 32'(sys_in), 32'(pat[i]));
         if (i > 0) check("ce_in_interval", 32'(t - tprev), 32'(DIV));
         tprev = t;
         wait_ov();
         e = exp_q.pop_front();
         check("out_data", 32'(out_data), 32'(e));
         check("sample_count", 32'(sample_count), 32'(i + 1));
         check("flags_clean", 32'({underrun, overrun, timeout}), 32'h0);
      end

      // Underrun: no sample offered, previous sample re-issued.
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      exp_q.push_back(resp_of(last_in));
      wait_ce(t);
      check("ce_in_interval_underrun", 32'(t - tprev), 32'(DIV));
      check("sys_in_hold", 32'(sys_in), 32'h0123);
      check("underrun_set", 32'(underrun), 32'h1);
      wait_ov();
      e = exp_q.pop_front();
      last_cap = e;
      check("out_data_underrun", 32'(out_data), 32'(e));
      check("sample_count_underrun", 32'(sample_count), 32'd4);
      check("in_ready_pulses_a", 32'(rdy_cnt), 32'd3);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("underrun_clr", 32'(underrun), 32'h0);
      in_valid = 1'b1;

      // Timeout: response arrives long after the window closes.
      resp_delay = 11;
      in_data    = 16'h1111;
      wait_ce(t);
      check("sys_in_timeout", 32'(sys_in), 32'h1111);
      repeat (7) @(negedge clk);
      check("timeout_early", 32'(timeout), 32'h0);
      @(negedge clk);
      check("timeout_set", 32'(timeout), 32'h1);
      check("timeout_out_valid", 32'(out_valid), 32'h0);
      check("timeout_out_data", 32'(out_data), 32'(last_cap));
      repeat (5) @(negedge clk);
      check("late_ce_out_count", 32'(sample_count), 32'd4);
      check("late_ce_out_valid", 32'(out_valid), 32'h0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("timeout_clr", 32'(timeout), 32'h0);

      // Overrun: downstream stalls across two captures.
      resp_delay = 3;
      out_ready  = 1'b0;
      in_data    = 16'h2222;
      exp_q.push_back(resp_of(16'h2222));
      wait_ce(t);
      wait_ov();
      check("overrun_first", 32'(overrun), 32'h0);
      check("out_data_first", 32'(out_data), 32'(exp_q[0]));
      in_data = 16'h3333;
      exp_q.push_back(resp_of(16'h3333));
      wait_ce(t);
      repeat (4) @(negedge clk);
      void'(exp_q.pop_front());
      e = exp_q.pop_front();
      check("overrun_set", 32'(overrun), 32'h1);
      check("overrun_out_valid", 32'(out_valid), 32'h1);
      check("overrun_out_data", 32'(out_data), 32'(e));
      check("overrun_count", 32'(sample_count), 32'd6);
      out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_drain", 32'(out_valid), 32'h0);

      // Reset pulse in the middle of WAIT; the late strobe must be ignored.
      resp_delay = 4;
      in_data    = 16'h4444;
      wait_ce(t);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset("mid_wait_rst");

      // Count wrap from a preset value near the top.
      resp_delay = 3;
      force dut.sample_count_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.sample_count_q;
      check("count_preset", 32'(sample_count), 32'hFFFE);
      for (int i = 0; i < 2; i++) begin
         in_data = (i == 0) ? 16'h5555 : 16'h6666;
         exp_q.push_back(resp_of(in_data));
         wait_ce(t);
         wait_ov();
         e = exp_q.pop_front();
         check("wrap_out_data", 32'(out_data), 32'(e));
         check("wrap_count", 32'(sample_count), (i == 0) ? 32'hFFFF : 32'h0);
         check("wrap_flags", 32'({underrun, overrun, timeout}), 32'h0);
      end

      // Enable drops during a transaction: it completes, no further ticks.
      in_data = 16'h7777;
      exp_q.push_back(resp_of(16'h7777));
      wait_ce(t);
      en = 1'b0;
      wait_ov();
      e = exp_q.pop_front();
      check("en_low_out_data", 32'(out_data), 32'(e));
      check("en_low_count", 32'(sample_count), 32'd1);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (sys_ce_in === 1'b1) n++;
      end
      check("no_tick_after_en_low", 32'(n), 32'h0);
      check("in_ready_pulses_total", 32'(rdy_cnt), 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lti_sample_driver.md
LTI_SAMPLE_DRIVER -- requirements
Module: lti_sample_driver

Interface
REQ-001 Parameter IW, default 16: width of samples driven into the LTI system.
REQ-002 Parameter OW, default 20: width of the LTI system output captured.
REQ-003 Parameter DIV, default 100: clock cycles per sample period; SHALL satisfy DIV >= TO+3.
REQ-004 Parameter TO, default 8: maximum cycles from sys_ce_in to sys_ce_out before a timeout is declared.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  enables sample-period counter; low freezes counter at 0 and blocks new ticks.
REQ-008 clr  in  1  one-cycle pulse clearing sticky flags.
REQ-009 in_data  in  IW  upstream sample.
REQ-010 in_valid  in  1  upstream sample available.
REQ-011 in_ready  out  1  upstream sample accepted this cycle.
REQ-012 sys_in  out  IW  sample presented to LTI sig_in_1.
REQ-013 sys_ce_in  out  1  one-cycle strobe to LTI ce_in.
REQ-014 sys_out  in  OW  LTI sig_out_1.
REQ-015 sys_ce_out  in  1  LTI ce_out strobe.
REQ-016 out_data  out  OW  captured LTI output.
REQ-017 out_valid  out  1  out_data holds an unconsumed result.
REQ-018 out_ready  in  1  downstream accepts out_data when high with out_valid.
REQ-019 underrun, overrun, timeout  out  1 each  sticky error flags.
REQ-020 sample_count  out  16  count of successfully captured results, wraps 0xFFFF->0.

Function
REQ-021 Period counter SHALL count 0..DIV-1 while en=1 and assert internal tick for one cycle when at DIV-1, then wrap to 0.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-023 IDLE->ISSUE on tick; otherwise remain.
REQ-024 In ISSUE: if in_valid, in_ready=1 for that cycle and in_data is latched to sys_in; else sys_in holds previous value and underrun sets.
REQ-025 sys_ce_in SHALL be asserted exactly the cycle after ISSUE (registered), with sys_in already stable; FSM enters WAIT in that same cycle.
REQ-026 In WAIT a cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-027 sys_ce_out in WAIT SHALL latch sys_out into out_data, set out_valid next cycle, increment sample_count, return to IDLE.
REQ-028 If wait counter reaches TO without sys_ce_out, timeout sets, FSM returns to IDLE, out_data/out_valid unchanged.
REQ-029 sys_ce_out outside WAIT SHALL be ignored (no capture, no count).
REQ-030 Capture while out_valid=1 and out_ready=0 SHALL overwrite out_data and set overrun; out_valid stays 1.
REQ-031 out_valid clears the cycle after out_valid&out_ready unless a capture coincides, in which case out_valid stays 1 with new data and overrun is not set.
REQ-032 clr coincident with a flag-setting event: set wins.
REQ-033 en falling mid-transaction SHALL not abort ISSUE/WAIT; only further ticks stop.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force: FSM IDLE, counters 0, sys_in=0, sys_ce_in=0, in_ready=0, out_data=0, out_valid=0, all flags 0, sample_count=0.
REQ-035 Reset mid-WAIT SHALL discard the pending transaction; a later sys_ce_out is ignored.

Structure
REQ-036 FSM state encoding and flag bit indices SHALL live in shared package lti_pkg.
REQ-037 Period counter SHALL be sub-module lti_tick_gen (params DIV; ports clk, rst_n, en, tick).

Verification
REQ-038 DIV=16, TO=8, in_valid=1, in_data=0x0123, responder ce_out 3 cycles after ce_in -> sys_ce_in every 16 cycles, out_data=sys_out, sample_count increments each period, no flags.
REQ-039 in_valid=0 at tick -> underrun=1, sys_in retains 0x0123, sys_ce_in still pulses.
REQ-040 Responder never asserts ce_out -> timeout=1 exactly 8 cycles after sys_ce_in, FSM IDLE, out_valid unchanged.
REQ-041 out_ready=0 for two periods -> second capture sets overrun, out_data = second result.
REQ-042 rst_n low for 1 cycle during WAIT, ce_out arrives 2 cycles later -> all outputs at reset values, no capture, sample_count=0.
REQ-043 sample_count preset path: 65536 captures -> count wraps to 0, no flags.
